// File: rtl/sha1_stream_core.sv
// Streaming SHA-1 compression engine: ROUNDS_PER_CYCLE unrolled rounds per clock over a
// 16-word sliding message schedule, chaining H across the blocks of a multi-block message.
module sha1_stream_core #(
    parameter int           ROUNDS_PER_CYCLE = 1,
    parameter logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
    input  logic         abort,
    output logic         busy,
    output logic [6:0]   round_cnt,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [159:0] digest
);
    localparam int RPC = ROUNDS_PER_CYCLE;
    localparam int EXT = 16 + RPC;

    if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 5 || RPC == 8 ||
          RPC == 10 || RPC == 16 || RPC == 20)) begin : g_bad_rpc
        $error("sha1_stream_core: ROUNDS_PER_CYCLE must divide 80 and be at most 20");
    end

    typedef enum logic [1:0] {IDLE, ROUND, ADD, OUT} state_t;

    state_t       state, state_nx;
    logic [31:0]  w_q [16];
    logic [31:0]  a_q, b_q, c_q, d_q, e_q;
    logic [159:0] h_q;
    logic         last_q;
    logic [6:0]   rc_q;

    logic [31:0]  w_ext [EXT];
    logic [31:0]  ra, rb, rc, rd, re, f, k, tmp;
    logic [6:0]   t;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // the producer holds valid and data until then, ready never depends on valid.
    assign blk_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign digest_valid = (state == OUT);
    assign digest       = digest_valid ? h_q : '0;
    assign round_cnt    = rc_q;

    // Window holds W[t..t+15]; the RPC words past it are expanded here for this cycle's rounds.
    always_comb begin
        for (int i = 0; i < 16; i++) w_ext[i] = w_q[i];
        for (int i = 16; i < EXT; i++)
            w_ext[i] = rotl(w_ext[i-3] ^ w_ext[i-8] ^ w_ext[i-14] ^ w_ext[i-16], 1);
        ra  = a_q;
        rb  = b_q;
        rc  = c_q;
        rd  = d_q;
        re  = e_q;
        f   = '0;
        k   = '0;
        tmp = '0;
        t   = '0;
        for (int j = 0; j < RPC; j++) begin
            t = rc_q + 7'(j);
            if (t < 7'd20) begin
                f = (rb & rc) | (~rb & rd);
                k = 32'h5A827999;
            end else if (t < 7'd40) begin
                f = rb ^ rc ^ rd;
                k = 32'h6ED9EBA1;
            end else if (t < 7'd60) begin
                f = (rb & rc) | (rb & rd) | (rc & rd);
                k = 32'h8F1BBCDC;
            end else begin
                f = rb ^ rc ^ rd;
                k = 32'hCA62C1D6;
            end
            tmp = rotl(ra, 5) + f + re + k + w_ext[j];
            re  = rd;
            rd  = rc;
            rc  = rotl(rb, 30);
            rb  = ra;
            ra  = tmp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (blk_valid) state_nx = ROUND;
            ROUND:   if (rc_q == 7'(80 - RPC)) state_nx = ADD;
            ADD:     state_nx = last_q ? OUT : IDLE;
            OUT:     if (digest_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rc_q   <= '0;
            last_q <= 1'b0;
            h_q    <= IV;
            {a_q, b_q, c_q, d_q, e_q} <= '0;
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
        end else if (abort) begin
            rc_q <= '0;
            h_q  <= IV;
        end else begin
            case (state)
                IDLE: if (blk_valid) begin
                    for (int i = 0; i < 16; i++) w_q[i] <= blk_data[511 - 32*i -: 32];
                    if (blk_first) begin
                        {a_q, b_q, c_q, d_q, e_q} <= IV;
                        h_q <= IV;
                    end else begin
                        {a_q, b_q, c_q, d_q, e_q} <= h_q;
                    end
                    last_q <= blk_last;
                    rc_q   <= '0;
                end
                ROUND: begin
                    for (int i = 0; i < 16; i++) w_q[i] <= w_ext[i + RPC];
                    a_q  <= ra;
                    b_q  <= rb;
                    c_q  <= rc;
                    d_q  <= rd;
                    e_q  <= re;
                    rc_q <= rc_q + 7'(RPC);
                end
                ADD: h_q <= {h_q[159:128] + a_q, h_q[127:96] + b_q, h_q[95:64] + c_q,
                             h_q[63:32] + d_q, h_q[31:0] + e_q};
                // Consumed digest ends the message; the next block starts from IV.
                OUT: if (digest_ready) h_q <= IV;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sha1_stream_core.sv
// Directed bench for sha1_stream_core: known SHA-1 vectors, latency, hold, abort and reset.
module tb_sha1_stream_core;
    localparam logic [159:0] D_ABC   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] D_EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
    localparam logic [159:0] D_TWO   = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;
    localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] B_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B_TWO2  = {448'h0, 32'h00000000, 32'h000001c0};

    logic         clk, rst;
    logic         blk_valid, blk_ready, blk_first, blk_last, abort, busy;
    logic [511:0] blk_data;
    logic [6:0]   round_cnt;
    logic         digest_valid, digest_ready;
    logic [159:0] digest;

    logic         x_valid, x_first, x_last, x_abort, x_dready;
    logic [511:0] x_data;
    logic         x5_ready, x5_busy, x5_dv, x20_ready, x20_busy, x20_dv;
    logic [6:0]   x5_rc, x20_rc;
    logic [159:0] x5_digest, x20_digest;

    int           n_vec = 0;
    int           n_err = 0;
    logic [159:0] exp_q[$];
    logic [159:0] exp;

    sha1_stream_core #(.ROUNDS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .blk_data(blk_data), .blk_first(blk_first), .blk_last(blk_last), .abort(abort),
        .busy(busy), .round_cnt(round_cnt), .digest_valid(digest_valid),
        .digest_ready(digest_ready), .digest(digest));

    sha1_stream_core #(.ROUNDS_PER_CYCLE(5)) dut5 (
        .clk(clk), .rst(rst), .blk_valid(x_valid), .blk_ready(x5_ready),
        .blk_data(x_data), .blk_first(x_first), .blk_last(x_last), .abort(x_abort),
        .busy(x5_busy), .round_cnt(x5_rc), .digest_valid(x5_dv),
        .digest_ready(x_dready), .digest(x5_digest));

    sha1_stream_core #(.ROUNDS_PER_CYCLE(20)) dut20 (
        .clk(clk), .rst(rst), .blk_valid(x_valid), .blk_ready(x20_ready),
        .blk_data(x_data), .blk_first(x_first), .blk_last(x_last), .abort(x_abort),
        .busy(x20_busy), .round_cnt(x20_rc), .digest_valid(x20_dv),
        .digest_ready(x_dready), .digest(x20_digest));

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Driver tasks; all are entered and left at a falling edge
    task automatic send_block(input logic [511:0] d, input logic f, input logic l);
        int n = 0;
        blk_data  = d;
        blk_first = f;
        blk_last  = l;
        blk_valid = 1'b1;
        while (!blk_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!blk_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: blk_ready=%b after %0d cycles, required 1", blk_ready, n);
        end
        @(negedge clk);
        blk_valid = 1'b0;
    endtask

    task automatic wait_digest(output int lat);
        lat = 0;
        while (!digest_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_digest();
        digest_ready = 1'b1;
        @(negedge clk);
        digest_ready = 1'b0;
    endtask

    // Tests
    task automatic test_reset();
        n_vec++; if (blk_ready !== 1'b1) begin n_err++; $display("FAIL reset_blk_ready: got %b, required 1", blk_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_vec++; if (digest_valid !== 1'b0) begin n_err++; $display("FAIL reset_digest_valid: got %b, required 0", digest_valid); end
        n_vec++; if (round_cnt !== 7'd0) begin n_err++; $display("FAIL reset_round_cnt: got %0d, required 0", round_cnt); end
        n_vec++; if (digest !== 160'h0) begin n_err++; $display("FAIL reset_digest: got %h, required 0", digest); end
    endtask

    task automatic test_abc_latency();
        int lat;
        exp_q.push_back(D_ABC);
        send_block(B_ABC, 1'b1, 1'b1);
        wait_digest(lat);
        n_vec++; if (lat !== 81) begin n_err++; $display("FAIL abc_latency: got %0d, required 81", lat); end
        exp = exp_q.pop_front();
        n_vec++; if (digest !== exp) begin n_err++; $display("FAIL abc_digest: got %h, required %h", digest, exp); end
        release_digest();
    endtask

    task automatic test_empty_rpc5_rpc20();
        int n = 0;
        int l5 = -1;
        int l20 = -1;
        x_data  = B_EMPTY;
        x_first = 1'b1;
        x_last  = 1'b1;
        x_valid = 1'b1;
        @(negedge clk);
        x_valid = 1'b0;
        while ((l5 < 0 || l20 < 0) && n < 60) begin
            @(negedge clk);
            n++;
            if (x5_dv && l5 < 0) l5 = n;
            if (x20_dv && l20 < 0) l20 = n;
        end
        n_vec++; if (l5 !== 17) begin n_err++; $display("FAIL empty_rpc5_latency: got %0d, required 17", l5); end
        n_vec++; if (l20 !== 5) begin n_err++; $display("FAIL empty_rpc20_latency: got %0d, required 5", l20); end
        n_vec++; if (x5_digest !== D_EMPTY) begin n_err++; $display("FAIL empty_rpc5_digest: got %h, required %h", x5_digest, D_EMPTY); end
        n_vec++; if (x20_digest !== D_EMPTY) begin n_err++; $display("FAIL empty_rpc20_digest: got %h, required %h", x20_digest, D_EMPTY); end
        x_dready = 1'b1;
        @(negedge clk);
        x_dready = 1'b0;
        n_vec++; if (x5_dv !== 1'b0 || x20_dv !== 1'b0) begin n_err++; $display("FAIL empty_handoff: got dv5=%b dv20=%b, required 0 0", x5_dv, x20_dv); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int lat;
        exp_q.push_back(D_TWO);
        blk_data  = B_TWO1;
        blk_first = 1'b1;
        blk_last  = 1'b0;
        blk_valid = 1'b1;
        @(negedge clk);
        blk_data  = B_TWO2;
        blk_first = 1'b0;
        blk_last  = 1'b1;
        while (!blk_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_vec++; if (n + 1 !== 82) begin n_err++; $display("FAIL b2b_gap: got %0d, required 82", n + 1); end
        @(negedge clk);
        blk_valid = 1'b0;
        wait_digest(lat);
        exp = exp_q.pop_front();
        n_vec++; if (digest !== exp) begin n_err++; $display("FAIL b2b_digest: got %h, required %h", digest, exp); end
        release_digest();
    endtask

    task automatic test_hold();
        int lat;
        send_block(B_ABC, 1'b1, 1'b1);
        wait_digest(lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_vec++;
            if (digest !== D_ABC || digest_valid !== 1'b1 || blk_ready !== 1'b0) begin
                n_err++;
                $display("FAIL hold_cycle%0d: got dv=%b rdy=%b dig=%h, required 1 0 %h",
                         i, digest_valid, blk_ready, digest, D_ABC);
            end
        end
        release_digest();
        n_vec++; if (digest_valid !== 1'b0 || blk_ready !== 1'b1) begin n_err++; $display("FAIL hold_release: got dv=%b rdy=%b, required 0 1", digest_valid, blk_ready); end
        exp_q.push_back(D_ABC);
        send_block(B_ABC, 1'b0, 1'b1);
        wait_digest(lat);
        exp = exp_q.pop_front();
        n_vec++; if (digest !== exp) begin n_err++; $display("FAIL hold_iv_restore_digest: got %h, required %h", digest, exp); end
        release_digest();
    endtask

    task automatic test_abort();
        int n = 0;
        int lat;
        logic seen = 1'b0;
        blk_data  = B_ABC;
        blk_first = 1'b1;
        blk_last  = 1'b1;
        blk_valid = 1'b1;
        abort     = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        abort     = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_beats_accept: got busy=%b, required 0", busy); end
        send_block(B_ABC, 1'b1, 1'b1);
        while (round_cnt !== 7'd40 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_vec++; if (round_cnt !== 7'd40) begin n_err++; $display("FAIL abort_reach_40: got %0d, required 40", round_cnt); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || round_cnt !== 7'd0 || blk_ready !== 1'b1 || digest_valid !== 1'b0) begin
            n_err++;
            $display("FAIL abort_flush: got busy=%b rc=%0d rdy=%b dv=%b, required 0 0 1 0",
                     busy, round_cnt, blk_ready, digest_valid);
        end
        for (int i = 0; i < 90; i++) begin
            @(negedge clk);
            if (digest_valid) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_no_digest: got seen=%b, required 0", seen); end
        exp_q.push_back(D_ABC);
        send_block(B_ABC, 1'b1, 1'b1);
        wait_digest(lat);
        exp = exp_q.pop_front();
        n_vec++; if (digest !== exp) begin n_err++; $display("FAIL abort_then_abc: got %h, required %h", digest, exp); end
        release_digest();
    endtask

    task automatic test_rst_mid();
        int lat;
        send_block(B_ABC, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (blk_ready !== 1'b1 || busy !== 1'b0 || digest_valid !== 1'b0 ||
            round_cnt !== 7'd0 || digest !== 160'h0) begin
            n_err++;
            $display("FAIL rst_mid_async: got rdy=%b busy=%b dv=%b rc=%0d dig=%h, required 1 0 0 0 0",
                     blk_ready, busy, digest_valid, round_cnt, digest);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(D_ABC);
        send_block(B_ABC, 1'b0, 1'b1);
        wait_digest(lat);
        exp = exp_q.pop_front();
        n_vec++; if (digest !== exp) begin n_err++; $display("FAIL rst_nonfirst_abc: got %h, required %h", digest, exp); end
        release_digest();
    endtask

    task automatic test_chain_discard();
        int lat;
        send_block(B_TWO1, 1'b1, 1'b0);
        exp_q.push_back(D_ABC);
        send_block(B_ABC, 1'b1, 1'b1);
        wait_digest(lat);
        exp = exp_q.pop_front();
        n_vec++; if (digest !== exp) begin n_err++; $display("FAIL chain_discard: got %h, required %h", digest, exp); end
        release_digest();
    endtask

    initial begin
        rst          = 1'b1;
        blk_valid    = 1'b0;
        blk_data     = '0;
        blk_first    = 1'b0;
        blk_last     = 1'b0;
        abort        = 1'b0;
        digest_ready = 1'b0;
        x_valid      = 1'b0;
        x_data       = '0;
        x_first      = 1'b0;
        x_last       = 1'b0;
        x_abort      = 1'b0;
        x_dready     = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_abc_latency();
        test_empty_rpc5_rpc20();
        test_back_to_back();
        test_hold();
        test_abort();
        test_rst_mid();
        test_chain_discard();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
